// File: rtl/ex_fwd_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the EX forwarding/hazard controller.
// The datapath side uses the master modport; the controller uses slave.
interface ex_fwd_hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  branch_taken;
  logic                  dmem_stall;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic                  stall_if;
  logic                  stall_id;
  logic                  flush_id;
  logic                  flush_ex;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_mem_read,
    output branch_taken, dmem_stall,
    input  fwd_a_sel, fwd_b_sel, stall_if, stall_id, flush_id, flush_ex, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_mem_read,
    input  branch_taken, dmem_stall,
    output fwd_a_sel, fwd_b_sel, stall_if, stall_id, flush_id, flush_ex, stall_cnt
  );
endinterface

// File: rtl/ex_fwd_hazard_ctrl.sv
// EX-stage forwarding and hazard controller: tracks rd info for EX/MEM/WB, drives operand
// forwarding selects, load-use stalls, branch flushes and dmem freeze.
module ex_fwd_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  ex_fwd_hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  use_rs1;
    logic                  use_rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } ex_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
  } dst_t;

  ex_t              ex_q, ex_d;
  dst_t             mem_q, mem_d;
  dst_t             wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic stall_if, stall_id, flush_id, flush_ex;

  // x0 never forwards; MEM wins over WB so the newest producer is used.
  function automatic logic [1:0] fwd_sel(input logic                  need,
                                         input logic [REG_ADDR_W-1:0] rs,
                                         input dst_t                  mem,
                                         input dst_t                  wb);
    logic [1:0] sel;
    sel = 2'b00;
    if (need && mem.valid && mem.reg_write && (mem.rd != '0) && (mem.rd == rs)) begin
      sel = 2'b10;
    end else if (need && wb.valid && wb.reg_write && (wb.rd != '0) && (wb.rd == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    load_use = bus.id_valid && ex_q.valid && ex_q.mem_read && ex_q.reg_write &&
               (ex_q.rd != '0) &&
               ((bus.id_use_rs1 && (bus.id_rs1 == ex_q.rd)) ||
                (bus.id_use_rs2 && (bus.id_rs2 == ex_q.rd)));
  end

  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    stall_cnt_d = stall_cnt_q;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;

    if (bus.dmem_stall) begin
      // Whole pipeline frozen; a pending branch is re-presented once memory is ready.
      stall_if = 1'b1;
      stall_id = 1'b1;
    end else begin
      mem_d = '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write};
      wb_d  = mem_q;
      if (bus.branch_taken) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
        ex_d     = '0;
      end else if (load_use) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
        ex_d     = '0;
        if (stall_cnt_q != '1) begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
      end else begin
        ex_d = '{valid:     bus.id_valid,
                 rs1:       bus.id_rs1,
                 rs2:       bus.id_rs2,
                 use_rs1:   bus.id_use_rs1,
                 use_rs2:   bus.id_use_rs2,
                 rd:        bus.id_rd,
                 reg_write: bus.id_reg_write,
                 mem_read:  bus.id_mem_read};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.fwd_a_sel = fwd_sel(ex_q.valid && ex_q.use_rs1, ex_q.rs1, mem_q, wb_q);
  assign bus.fwd_b_sel = fwd_sel(ex_q.valid && ex_q.use_rs2, ex_q.rs2, mem_q, wb_q);
  assign bus.stall_if  = stall_if;
  assign bus.stall_id  = stall_id;
  assign bus.flush_id  = flush_id;
  assign bus.flush_ex  = flush_ex;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ex_fwd_hazard_ctrl.sv
// Directed scoreboard bench for ex_fwd_hazard_ctrl: each step pushes its expected outputs
// and pops them for comparison once the DUT outputs have settled after the falling edge.
module tb_ex_fwd_hazard_ctrl;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned CntW     = 6;
  localparam int unsigned CntMax   = (1 << CntW) - 1;
  localparam logic [1:0]  Rf       = 2'b00;
  localparam logic [1:0]  Wb       = 2'b01;
  localparam logic [1:0]  Mem      = 2'b10;

  typedef struct packed {
    logic                v;
    logic [RegAddrW-1:0] rs1;
    logic [RegAddrW-1:0] rs2;
    logic                u1;
    logic                u2;
    logic [RegAddrW-1:0] rd;
    logic                rw;
    logic                mr;
  } id_t;

  typedef struct packed {
    logic [1:0]      a;
    logic [1:0]      b;
    logic            sif;
    logic            sid;
    logic            fid;
    logic            fex;
    logic [CntW-1:0] cnt;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  exp_t  exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  ex_fwd_hazard_ctrl_if #(.REG_ADDR_W(RegAddrW), .CNT_W(CntW)) bus ();

  ex_fwd_hazard_ctrl #(.REG_ADDR_W(RegAddrW), .CNT_W(CntW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic id_t ins(input logic v, input int rs1, input int rs2, input logic u1,
                              input logic u2, input int rd, input logic rw, input logic mr);
    ins = '{v: v, rs1: RegAddrW'(rs1), rs2: RegAddrW'(rs2), u1: u1, u2: u2,
            rd: RegAddrW'(rd), rw: rw, mr: mr};
  endfunction

  function automatic exp_t mk_exp(input logic [1:0] a, input logic [1:0] b, input logic sif,
                                  input logic sid, input logic fid, input logic fex,
                                  input int unsigned cnt);
    mk_exp = '{a: a, b: b, sif: sif, sid: sid, fid: fid, fex: fex, cnt: CntW'(cnt)};
  endfunction

  function automatic exp_t idle(input int unsigned cnt);
    idle = mk_exp(Rf, Rf, 1'b0, 1'b0, 1'b0, 1'b0, cnt);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input id_t i, input logic br, input logic dm);
    bus.id_valid     = i.v;
    bus.id_rs1       = i.rs1;
    bus.id_rs2       = i.rs2;
    bus.id_use_rs1   = i.u1;
    bus.id_use_rs2   = i.u2;
    bus.id_rd        = i.rd;
    bus.id_reg_write = i.rw;
    bus.id_mem_read  = i.mr;
    bus.branch_taken = br;
    bus.dmem_stall   = dm;
  endtask

  task automatic compare_out();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_eq({t, ".fwd_a"},     32'(bus.fwd_a_sel), 32'(e.a));
    check_eq({t, ".fwd_b"},     32'(bus.fwd_b_sel), 32'(e.b));
    check_eq({t, ".stall_if"},  32'(bus.stall_if),  32'(e.sif));
    check_eq({t, ".stall_id"},  32'(bus.stall_id),  32'(e.sid));
    check_eq({t, ".flush_id"},  32'(bus.flush_id),  32'(e.fid));
    check_eq({t, ".flush_ex"},  32'(bus.flush_ex),  32'(e.fex));
    check_eq({t, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(e.cnt));
  endtask

  task automatic step(input string tag, input id_t i, input logic br, input logic dm,
                      input exp_t e);
    @(negedge clk);
    drive(i, br, dm);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #2;
    compare_out();
  endtask

  initial begin
    id_t nop, lw, add, lws;
    logic [31:0] r;
    int unsigned c;
    nop = '0;

    // Reset held with random ID traffic; branch/dmem kept low so outputs must all be idle.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      r = $urandom;
      drive(id_t'(r[$bits(id_t)-1:0]), 1'b0, 1'b0);
      exp_q.push_back(idle(0));
      tag_q.push_back("rst_hold");
      #2;
      compare_out();
    end
    drive(nop, 1'b0, 1'b0);
    rst_n = 1'b1;
    step("rst_rel", nop, 1'b0, 1'b0, idle(0));

    // Writer in MEM, reader in EX.
    step("fwd_mem0", ins(1, 1, 2, 1, 1, 5, 1, 0), 1'b0, 1'b0, idle(0));
    step("fwd_mem1", ins(1, 5, 4, 1, 1, 6, 1, 0), 1'b0, 1'b0, idle(0));
    step("fwd_mem2", nop, 1'b0, 1'b0, mk_exp(Mem, Rf, 0, 0, 0, 0, 0));
    step("fwd_mem3", nop, 1'b0, 1'b0, idle(0));
    step("fwd_mem4", nop, 1'b0, 1'b0, idle(0));

    // Two writers of x7: newest (MEM) must win.
    step("prio0", ins(1, 0, 0, 0, 0, 7, 1, 0), 1'b0, 1'b0, idle(0));
    step("prio1", ins(1, 0, 0, 0, 0, 7, 1, 0), 1'b0, 1'b0, idle(0));
    step("prio2", ins(1, 9, 7, 0, 1, 10, 1, 0), 1'b0, 1'b0, idle(0));
    step("prio3", nop, 1'b0, 1'b0, mk_exp(Rf, Mem, 0, 0, 0, 0, 0));
    step("prio4", nop, 1'b0, 1'b0, idle(0));
    step("prio5", nop, 1'b0, 1'b0, idle(0));

    // Single writer, reader three behind: WB forward.
    step("fwd_wb0", ins(1, 0, 0, 0, 0, 8, 1, 0), 1'b0, 1'b0, idle(0));
    step("fwd_wb1", nop, 1'b0, 1'b0, idle(0));
    step("fwd_wb2", ins(1, 8, 3, 1, 1, 11, 1, 0), 1'b0, 1'b0, idle(0));
    step("fwd_wb3", nop, 1'b0, 1'b0, mk_exp(Wb, Rf, 0, 0, 0, 0, 0));
    step("fwd_wb4", nop, 1'b0, 1'b0, idle(0));
    step("fwd_wb5", nop, 1'b0, 1'b0, idle(0));

    // Writer to x0 is never forwarded.
    step("x0_0", ins(1, 0, 0, 0, 0, 0, 1, 0), 1'b0, 1'b0, idle(0));
    step("x0_1", ins(1, 0, 0, 1, 1, 12, 1, 0), 1'b0, 1'b0, idle(0));
    step("x0_2", nop, 1'b0, 1'b0, idle(0));
    step("x0_3", nop, 1'b0, 1'b0, idle(0));
    step("x0_4", nop, 1'b0, 1'b0, idle(0));

    // Load-use: one stall cycle, then WB forward.
    lw  = ins(1, 2, 0, 1, 0, 3, 1, 1);
    add = ins(1, 3, 4, 1, 1, 13, 1, 0);
    step("lu0", lw, 1'b0, 1'b0, idle(0));
    step("lu1", add, 1'b0, 1'b0, mk_exp(Rf, Rf, 1, 1, 0, 1, 0));
    step("lu2", add, 1'b0, 1'b0, idle(1));
    step("lu3", nop, 1'b0, 1'b0, mk_exp(Wb, Rf, 0, 0, 0, 0, 1));
    step("lu4", nop, 1'b0, 1'b0, idle(1));
    step("lu5", nop, 1'b0, 1'b0, idle(1));

    // Branch beats load-use; counter unchanged.
    step("br0", lw, 1'b0, 1'b0, idle(1));
    step("br1", add, 1'b1, 1'b0, mk_exp(Rf, Rf, 0, 0, 1, 1, 1));
    step("br2", nop, 1'b0, 1'b0, idle(1));
    step("br3", nop, 1'b0, 1'b0, idle(1));

    // dmem freeze over branch + load-use for 3 cycles, then the branch resumes.
    step("frz0", ins(1, 0, 0, 0, 0, 7, 1, 0), 1'b0, 1'b0, idle(1));
    step("frz1", ins(1, 7, 0, 1, 0, 3, 1, 1), 1'b0, 1'b0, idle(1));
    for (int k = 0; k < 3; k++) begin
      step("frz_hold", add, 1'b1, 1'b1, mk_exp(Mem, Rf, 1, 1, 0, 0, 1));
    end
    step("frz_rel", add, 1'b1, 1'b0, mk_exp(Mem, Rf, 0, 0, 1, 1, 1));
    step("frz3", nop, 1'b0, 1'b0, idle(1));
    step("frz4", nop, 1'b0, 1'b0, idle(1));

    // Back-to-back dependent loads: one stall per pair.
    step("b2b0", lw, 1'b0, 1'b0, idle(1));
    step("b2b1", ins(1, 3, 0, 1, 0, 4, 1, 1), 1'b0, 1'b0, mk_exp(Rf, Rf, 1, 1, 0, 1, 1));
    step("b2b2", ins(1, 3, 0, 1, 0, 4, 1, 1), 1'b0, 1'b0, idle(2));
    step("b2b3", ins(1, 4, 0, 1, 0, 14, 1, 0), 1'b0, 1'b0, mk_exp(Wb, Rf, 1, 1, 0, 1, 2));
    step("b2b4", ins(1, 4, 0, 1, 0, 14, 1, 0), 1'b0, 1'b0, idle(3));
    step("b2b5", nop, 1'b0, 1'b0, mk_exp(Wb, Rf, 0, 0, 0, 0, 3));
    step("b2b6", nop, 1'b0, 1'b0, idle(3));
    step("b2b7", nop, 1'b0, 1'b0, idle(3));

    // Saturation: 2^CntW+2 more stalls from a count of 3.
    lws = ins(1, 3, 0, 1, 0, 3, 1, 1);
    for (int i = 0; i < (1 << CntW) + 2; i++) begin
      c = (3 + i > CntMax) ? CntMax : 3 + i;
      step("sat_go", lws, 1'b0, 1'b0, idle(c));
      step("sat_stall", lws, 1'b0, 1'b0, mk_exp((i == 0) ? Rf : Wb, Rf, 1, 1, 0, 1, c));
    end
    step("sat_end", ins(1, 3, 0, 1, 0, 13, 1, 0), 1'b0, 1'b0, idle(CntMax));
    step("pre_rst", nop, 1'b0, 1'b1, mk_exp(Wb, Rf, 1, 1, 0, 0, CntMax));

    // Asynchronous reset in the middle of a freeze clears everything at once.
    rst_n = 1'b0;
    bus.dmem_stall = 1'b0;
    #1;
    exp_q.push_back(idle(0));
    tag_q.push_back("mid_rst");
    compare_out();
    @(negedge clk);
    drive(nop, 1'b0, 1'b0);
    rst_n = 1'b1;
    step("post_rst", nop, 1'b0, 1'b0, idle(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_fwd_hazard_ctrl.md
Name: ex_fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller for the execute stage of the 5-stage RISC-V pipeline.
- Tracks destination-register info for the instructions in EX, MEM and WB.
- Drives the select lines of the EX operand forwarding muxes (A and B).
- Generates load-use stalls, branch flushes and a global freeze on data-memory wait, and keeps a saturating stall counter for performance debug.

Parameters:
- REG_ADDR_W, 5: register index width.
- CNT_W, 16: width of the load-use stall counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs1  input  REG_ADDR_W  ID source register 1.
- id_rs2  input  REG_ADDR_W  ID source register 2.
- id_use_rs1  input  1  ID instruction reads rs1.
- id_use_rs2  input  1  ID instruction reads rs2.
- id_rd  input  REG_ADDR_W  ID destination register.
- id_reg_write  input  1  ID instruction writes rd.
- id_mem_read  input  1  ID instruction is a load.
- branch_taken  input  1  EX resolved a taken branch/jump this cycle.
- dmem_stall  input  1  data memory not ready; pipeline must freeze.
- fwd_a_sel  output  2  EX operand A select: 00 regfile, 01 WB result, 10 MEM result.
- fwd_b_sel  output  2  EX operand B select, same encoding.
- stall_if  output  1  hold PC.
- stall_id  output  1  hold IF/ID register.
- flush_id  output  1  clear IF/ID register to bubble.
- flush_ex  output  1  clear ID/EX register to bubble.
- stall_cnt  output  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Internal tracking state:
  - EX: ex_valid, ex_rs1, ex_rs2, ex_use_rs1, ex_use_rs2, ex_rd, ex_reg_write, ex_mem_read.
  - MEM: mem_valid, mem_rd, mem_reg_write.
  - WB: wb_valid, wb_rd, wb_reg_write.
- Reset (async, rst_n=0): all valid bits 0, all fields 0, stall_cnt 0. Outputs are therefore fwd_*_sel=00 and all stall/flush=0. A reset asserted mid-stall or mid-flush clears everything immediately; the first edge after deassertion follows normal rules.
- load_use (combinational) is 1 when all of the following hold:
  - id_valid and ex_valid and ex_mem_read and ex_reg_write;
  - ex_rd != 0;
  - (id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd).
- Output priority, highest first:
  1. dmem_stall=1: stall_if=stall_id=1, flush_id=flush_ex=0. No tracking register changes and stall_cnt holds. branch_taken is ignored; upstream holds it until dmem_stall drops.
  2. branch_taken=1: flush_id=flush_ex=1, stall_if=stall_id=0. Takes priority over load_use because ID is wrong-path. On the edge: EX <= bubble (ex_valid=0), MEM <= EX, WB <= MEM.
  3. load_use=1: stall_if=stall_id=1, flush_ex=1, flush_id=0. On the edge: EX <= bubble, MEM <= EX, WB <= MEM, and stall_cnt increments, saturating at all-ones.
  4. Otherwise: all stall/flush=0. On the edge: EX <= ID fields (ex_valid <= id_valid), MEM <= EX, WB <= MEM.
- Forwarding (combinational from EX/MEM/WB state only; 0-cycle latency):
  - fwd_a_sel=10 if ex_valid, ex_use_rs1, mem_valid, mem_reg_write, mem_rd!=0 and mem_rd==ex_rs1.
  - Else fwd_a_sel=01 if the same conditions hold against WB.
  - Else fwd_a_sel=00.
  - MEM beats WB when both match. fwd_b_sel is identical using rs2.
  - x0 is never forwarded. Selects are valid in every cycle, including during stall; the consumer ignores them when ex_valid=0.
- A load in MEM is never forwarded from the MEM result: the load-use stall guarantees that by the time the dependent instruction reaches EX the load is in WB, so fwd selects 01.
- Back-to-back loads with dependence: at most one stall cycle is inserted per dependent pair.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0, stall_cnt=0; release -> still 0 until the first valid instruction is tracked.
- EX->EX forward: issue add x5 (reg_write, rd=5), then sub using rs1=5 -> on the cycle sub is in EX, fwd_a_sel=10, fwd_b_sel=00.
- MEM->EX forward and priority: writes to x7 in consecutive instructions, then a reader of rs2=7 two behind -> fwd_b_sel=10 (newest). Reader three behind a single writer -> 01. Writer rd=0 -> 00.
- Load-use: lw x3 in EX, ID reads rs1=3 -> stall_if=stall_id=flush_ex=1 for exactly one cycle, stall_cnt 0->1. Next cycle fwd_a_sel=01.
- Branch vs load-use: load_use and branch_taken both 1 -> flush_id=flush_ex=1, stall=0, stall_cnt unchanged. With dmem_stall=1 as well -> stall_if=stall_id=1, flush=0, all state frozen for 3 cycles; on release, behaviour resumes exactly as before the freeze.
- Saturation: force 2^CNT_W+2 load-use stalls -> stall_cnt holds at all-ones.
